// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, result packet layout and source indices.
package cdb_pkg;

  localparam int N_CDB_SRC = 4;
  localparam int CDB_XLEN  = 32;
  localparam int CDB_TAG_W = 8;

  typedef struct packed {
    logic [CDB_XLEN-1:0]  data;
    logic [CDB_TAG_W-1:0] tag;
  } cdb_pkt_t;

  typedef enum logic [2:0] {
    SRC_ALU    = 3'd0,
    SRC_MULDIV = 3'd1,
    SRC_LSU    = 3'd2,
    SRC_VEC    = 3'd3
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake plus the serialised writeback result stream.
interface cdb_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC-1:0]       src_ready;
  logic [N_SRC*XLEN-1:0]  src_data;
  logic [N_SRC*TAG_W-1:0] src_tag;
  logic                   flush;
  logic [XLEN-1:0]        result_data;
  logic [TAG_W-1:0]       result_tag;
  logic                   result_valid;

  modport master (
    output src_valid, src_data, src_tag, flush,
    input  src_ready, result_data, result_tag, result_valid
  );

  modport slave (
    input  src_valid, src_data, src_tag, flush,
    output src_ready, result_data, result_tag, result_valid
  );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source elastic result buffer; flush empties it in one edge and wins over a push.
module cdb_src_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin serialiser of functional-unit results onto the CDB writeback stream.
// Optional CDB_ARB_PERF_EN adds perf_conflict_cnt (cycles with >=2 non-empty buffers).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int XLEN       = CDB_XLEN,
  parameter int N_SRC      = N_CDB_SRC,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = CDB_TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  cdb_arbiter_if.slave bus
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_cnt
`endif
);
  localparam int PKT_W = XLEN + TAG_W;
  localparam int LG_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PKT_W-1:0] head [N_SRC];
  logic [CNT_W-1:0] count [N_SRC];
  logic [N_SRC-1:0] full, empty, push, pop, req, ready;
  logic [PKT_W-1:0] head_sel;
  logic [LG_W-1:0]  grant_idx;
  logic             grant_any, do_grant;

  logic [LG_W-1:0]  last_grant_q, last_grant_d;
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign push[i] = bus.src_valid[i] && !full[i];
    cdb_src_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (bus.flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  ({bus.src_data[i*XLEN +: XLEN], bus.src_tag[i*TAG_W +: TAG_W]}),
      .head_o  (head[i]),
      .count_o (count[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < N_SRC; i++) ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
  end
  assign bus.src_ready = ready;

  // Eligibility comes from registered occupancy, so a fresh push waits one edge.
  assign req = ~empty;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % N_SRC;
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_idx = LG_W'(idx);
      end
    end
  end

  assign do_grant = grant_any && !bus.flush;
  assign head_sel = head[grant_idx];

  always_comb begin
    pop          = '0;
    last_grant_d = last_grant_q;
    valid_d      = do_grant;
    data_d       = data_q;
    tag_d        = tag_q;
    if (do_grant) begin
      pop[grant_idx] = 1'b1;
      last_grant_d   = grant_idx;
      data_d         = head_sel[PKT_W-1:TAG_W];
      tag_d          = head_sel[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LG_W'(N_SRC - 1);
      valid_q      <= 1'b0;
      data_q       <= '0;
      tag_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.result_data  = data_q;
  assign bus.result_tag   = tag_q;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_q;
  int          n_busy;

  always_comb begin
    n_busy = 0;
    for (int i = 0; i < N_SRC; i++) n_busy += int'(req[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         perf_q <= '0;
    else if (n_busy >= 2 && !bus.flush) perf_q <= perf_q + 32'd1;
  end

  assign perf_conflict_cnt = perf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; perf counter checks run only when CDB_ARB_PERF_EN is defined.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(N), .XLEN(XL), .TAG_W(TW)) bus ();

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_main, perf4;
  cdb_arbiter_if #(.N_SRC(N), .XLEN(XL), .TAG_W(TW)) bus4 ();
  cdb_arbiter #(.XLEN(XL), .N_SRC(N), .FIFO_DEPTH(4), .TAG_W(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .perf_conflict_cnt(perf4));
`endif

  cdb_arbiter #(.XLEN(XL), .N_SRC(N), .FIFO_DEPTH(2), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef CDB_ARB_PERF_EN
    , .perf_conflict_cnt(perf_main)
`endif
  );

  function automatic logic [31:0] data_of(input logic [7:0] tag);
    return {24'hC0DE00, tag};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_tag   = '0;
    bus.flush     = 1'b0;
`ifdef CDB_ARB_PERF_EN
    bus4.src_valid = '0;
    bus4.src_data  = '0;
    bus4.src_tag   = '0;
    bus4.flush     = 1'b0;
`endif
  endtask

  task automatic set_src(input int s, input logic [7:0] tag);
    bus.src_valid[s]          = 1'b1;
    bus.src_tag[s*TW +: TW]   = tag;
    bus.src_data[s*XL +: XL]  = data_of(tag);
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    #13;
    n_cmp++; if (bus.src_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %h want f", bus.src_ready); end
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.result_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.result_data); end
    n_cmp++; if (bus.result_tag !== 8'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", bus.result_tag); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat;
    do_reset();
    set_src(int'(SRC_LSU), 8'h15);
    bus.src_data[2*XL +: XL] = 32'hDEADBEEF;
    tick();
    idle();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL single_nobypass: valid got %b want 0", bus.result_valid); end
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.result_valid); end
    n_cmp++; if (bus.result_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", bus.result_data); end
    n_cmp++; if (bus.result_tag !== 8'h15) begin n_err++; $display("FAIL single_tag: got %h want 15", bus.result_tag); end
    tick();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL single_drop: valid got %b want 0", bus.result_valid); end
    n_cmp++; if (bus.result_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold: data got %h want deadbeef", bus.result_data); end
  endtask

  task automatic test_contention;
    logic [7:0] t;
    do_reset();
    for (int s = 0; s < N; s++) begin
      t = 8'h10 + 8'(s);
      set_src(s, t);
    end
    tick();
    idle();
    for (int i = 0; i < N; i++) begin
      tick();
      t = 8'h10 + 8'(i);
      n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== t || bus.result_data !== data_of(t)) begin
        n_err++; $display("FAIL contention_%0d: got v=%b tag=%h data=%h want v=1 tag=%h data=%h",
                          i, bus.result_valid, bus.result_tag, bus.result_data, t, data_of(t));
      end
    end
    tick();
    n_cmp++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL contention_end: valid got %b want 0", bus.result_valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] s0_tag  [8]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'hA4};
    logic       exp_rdy [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp_tag [10] = '{8'h00, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00};
    logic       exp_v   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_src(0, s0_tag[0]);
    set_src(1, 8'hB1);
    set_src(2, 8'hC2);
    set_src(3, 8'hD3);
    for (int e = 0; e < 10; e++) begin
      tick();
      if (e == 0) bus.src_valid[3:1] = 3'b000;
      if (e < 8) begin
        n_cmp++; if (bus.src_ready[0] !== exp_rdy[e]) begin
          n_err++; $display("FAIL bp_ready_e%0d: got %b want %b", e, bus.src_ready[0], exp_rdy[e]);
        end
      end
      n_cmp++;
      if (bus.result_valid !== exp_v[e] ||
          (exp_v[e] && (bus.result_tag !== exp_tag[e] || bus.result_data !== data_of(exp_tag[e])))) begin
        n_err++; $display("FAIL bp_out_e%0d: got v=%b tag=%h data=%h want v=%b tag=%h",
                          e, bus.result_valid, bus.result_tag, bus.result_data, exp_v[e], exp_tag[e]);
      end
      if (e + 1 < 8) set_src(0, s0_tag[e+1]);
      else           bus.src_valid[0] = 1'b0;
    end
  endtask

  task automatic test_flush;
    do_reset();
    set_src(0, 8'h50); set_src(1, 8'h60); set_src(2, 8'h70);
    tick();
    set_src(0, 8'h51); set_src(1, 8'h61); set_src(2, 8'h71);
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'h50) begin
      n_err++; $display("FAIL flush_pre: got v=%b tag=%h want v=1 tag=50", bus.result_valid, bus.result_tag);
    end
    n_cmp++; if (bus.src_ready !== 4'b1001) begin n_err++; $display("FAIL flush_pre_ready: got %b want 1001", bus.src_ready); end
    set_src(0, 8'h5F); set_src(1, 8'h6F); set_src(2, 8'h7F);
    bus.flush = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.src_ready !== 4'hF) begin n_err++; $display("FAIL flush_ready: got %h want f", bus.src_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.result_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_quiet_%0d: valid got %b tag=%h want 0", i, bus.result_valid, bus.result_tag);
      end
      tick();
    end
    // last grant stays at source 0 across the flush, so source 1 is served first
    set_src(0, 8'h80); set_src(1, 8'h81);
    tick();
    idle();
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'h81) begin
      n_err++; $display("FAIL flush_rr_first: got v=%b tag=%h want v=1 tag=81", bus.result_valid, bus.result_tag);
    end
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'h80) begin
      n_err++; $display("FAIL flush_rr_second: got v=%b tag=%h want v=1 tag=80", bus.result_valid, bus.result_tag);
    end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    for (int s = 0; s < N; s++) set_src(s, 8'h90 + 8'(s));
    tick();
    idle();
    tick();
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'h91) begin
      n_err++; $display("FAIL mid_stream: got v=%b tag=%h want v=1 tag=91", bus.result_valid, bus.result_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.result_valid !== 1'b0 || bus.result_data !== 32'h0 || bus.result_tag !== 8'h0) begin
      n_err++; $display("FAIL mid_async: got v=%b data=%h tag=%h want all 0", bus.result_valid, bus.result_data, bus.result_tag);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (bus.result_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_discard_%0d: valid got %b tag=%h want 0", i, bus.result_valid, bus.result_tag);
      end
    end
    set_src(0, 8'hE0); set_src(3, 8'hE3);
    tick();
    idle();
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'hE0) begin
      n_err++; $display("FAIL mid_first_grant: got v=%b tag=%h want v=1 tag=e0", bus.result_valid, bus.result_tag);
    end
    tick();
    n_cmp++; if (bus.result_valid !== 1'b1 || bus.result_tag !== 8'hE3) begin
      n_err++; $display("FAIL mid_second_grant: got v=%b tag=%h want v=1 tag=e3", bus.result_valid, bus.result_tag);
    end
  endtask

`ifdef CDB_ARB_PERF_EN
  task automatic test_perf;
    logic [31:0] exp_cnt [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd5};
    do_reset();
    n_cmp++; if (perf_main !== 32'd0 || perf4 !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: got main=%0d d4=%0d want 0", perf_main, perf4);
    end
    for (int e = 0; e < 8; e++) begin
      bus4.src_valid = (e < 3) ? 4'b0011 : 4'b0000;
      bus4.src_tag   = {16'h0, 8'h10 + 8'(e), 8'h00 + 8'(e)};
      tick();
      n_cmp++; if (perf4 !== exp_cnt[e]) begin
        n_err++; $display("FAIL perf_e%0d: got %0d want %0d", e, perf4, exp_cnt[e]);
      end
    end
    bus4.src_valid = 4'b0011;
    tick();
    bus4.src_valid = 4'b0000;
    bus4.flush     = 1'b1;
    n_cmp++; if (perf4 !== 32'd5) begin n_err++; $display("FAIL perf_refill: got %0d want 5", perf4); end
    tick();
    bus4.flush = 1'b0;
    n_cmp++; if (perf4 !== 32'd5) begin n_err++; $display("FAIL perf_flush_hold: got %0d want 5", perf4); end
    tick();
    n_cmp++; if (perf4 !== 32'd5) begin n_err++; $display("FAIL perf_after_flush: got %0d want 5", perf4); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_midstream();
`ifdef CDB_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the execute-stage functional units (ALU, MUL/DIV, LSU, vector unit) and serialises them into the single result stream consumed by the writeback stage, which broadcasts one result per cycle on the CDB. Each source gets a small elastic buffer with a valid/ready handshake. A round-robin arbiter grants one buffered result per cycle into a registered output. Sits between the functional-unit outputs and the writeback/CDB stage.

## Interface
- XLEN, 32, result data width
- N_SRC, 4, number of functional-unit sources (2..8)
- FIFO_DEPTH, 2, entries per source buffer (power of two, ≥2)
- TAG_W, 8, ROB/physical tag width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_valid  in  N_SRC  per-source result valid
- src_ready  out  N_SRC  per-source buffer can accept
- src_data  in  N_SRC*XLEN  per-source result data, source i at [i*XLEN +: XLEN]
- src_tag  in  N_SRC*TAG_W  per-source tag, source i at [i*TAG_W +: TAG_W]
- flush  in  1  pipeline flush (mispredict/exception); discards all buffered results
- result_data  out  XLEN  selected result to writeback
- result_tag  out  TAG_W  selected tag to writeback
- result_valid  out  1  result_data/result_tag valid this cycle; no backpressure from writeback

## Operation
- Accept: beat i transferred on an edge where src_valid[i] && src_ready[i]. src_ready[i] = (count[i] < FIFO_DEPTH), driven purely from registered count. A full buffer does not accept even when popped in the same cycle.
- Buffers are FIFO order per source; push and pop in the same cycle on a non-full, non-empty buffer leave count unchanged.
- Arbitration: combinational over non-empty buffers, round-robin starting at last_grant+1 mod N_SRC. Exactly one grant per cycle when any buffer is non-empty. Granted buffer pops; last_grant updates only on a grant.
- Output register: on a grant, loads result_data/result_tag from the granted head and sets result_valid=1. With no grant, result_valid=0 and data/tag hold their previous values.
- A beat pushed into an empty buffer is not eligible for grant in the same cycle (no bypass).
- Flush: at the edge where flush=1, all counts and pointers are cleared, result_valid←0, and same-cycle pushes are dropped. last_grant is unchanged. src_ready returns high the cycle after.
- Reset (asynchronous, any time): counts/pointers = 0, last_grant = N_SRC-1 (source 0 first), result_valid=0, result_data=0, result_tag=0. src_ready=all ones after reset. Reset mid-stream discards everything.

## Timing
- Latency: a beat accepted at edge k appears on result_* in the cycle after edge k+1 (one buffering edge plus one output edge), when uncontended.
- Throughput: one result per cycle aggregate. A single source sustains one per cycle with FIFO_DEPTH ≥ 2.
- Fairness: a non-empty source is granted within N_SRC cycles.
- No combinational path from src_valid or flush to any output.

## Configuration
- CDB_ARB_PERF_EN defined: adds output perf_conflict_cnt [31:0], incremented (wrapping) each cycle in which ≥2 buffers are non-empty and flush=0. Cleared by reset only, not by flush.
- Not defined: port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package cdb_pkg: N_CDB_SRC, CDB_TAG_W, typedef cdb_pkt_t {data, tag}, and the source index enum (SRC_ALU, SRC_MULDIV, SRC_LSU, SRC_VEC).
- Sub-module cdb_src_fifo: one per source (generate loop), with push/pop/flush, head output, count, full/empty. Round-robin arbiter and output register stay in the top.

## Test plan
- Single beat: src 2 pushes data 0xDEADBEEF tag 0x15 at edge 0 → result_valid=1, result_data=0xDEADBEEF, result_tag=0x15 after edge 1, result_valid=0 after edge 2.
- Contention after reset: all 4 sources push one beat (tags 0x10..0x13) at the same edge → tags appear 0x10,0x11,0x12,0x13 on four consecutive cycles.
- Backpressure: src 0 valid every cycle while srcs 1–3 each also hold one beat → src_ready[0] drops to 0 once count=2. No beat is lost or duplicated, and src 0 output order is preserved.
- Flush: 3 sources hold 2 beats each, flush pulsed for 1 cycle alongside a new push → result_valid=0 the next cycle, no pre-flush or same-cycle tag ever emitted, src_ready all 1 afterwards.
- Reset mid-stream: rst_n asserted asynchronously while results are streaming → result_valid/data/tag go to 0 immediately, and the first grant after release goes to source 0.
- With CDB_ARB_PERF_EN: 2 sources each hold 3 queued beats (depth raised to 4) → perf_conflict_cnt increments exactly once per cycle while both are non-empty.
